// File: rtl/cache_controller_if.sv
// Bundle of CPU, cache_memory and main-memory signals around the cache controller.
// master: the controller's view; slave: the surrounding CPU/cache/memory view.
interface cache_controller_if #(
    parameter int unsigned AW = 32
);
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_resp_valid;
    logic [7:0]    cpu_rdata;

    logic [AW-1:0] address_word;
    logic          try_read;
    logic          try_write;
    logic [7:0]    write_data;
    logic [3:0]    reset_age;
    logic [3:0]    increment_age;
    logic [7:0]    data;
    logic [7:0]    ages;
    logic          hit_miss;
    logic [3:0]    hit_miss_set;

    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_valid;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [7:0]    mem_wr_data;
    logic          mem_wr_ack;

    modport master (
        input  cpu_req_valid, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_rdata,
        output address_word, try_read, try_write, write_data, reset_age, increment_age,
        input  data, ages, hit_miss, hit_miss_set,
        output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        input  mem_rd_valid, mem_rd_data, mem_wr_ack
    );

    modport slave (
        output cpu_req_valid, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
        input  address_word, try_read, try_write, write_data, reset_age, increment_age,
        output data, ages, hit_miss, hit_miss_set,
        input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        output mem_rd_valid, mem_rd_data, mem_wr_ack
    );
endinterface

// File: rtl/cache_controller.sv
// Request sequencer in front of a 128-set 4-way cache_memory: true-LRU ages,
// read-miss block fill from main memory, write-through with no-write-allocate.
module cache_controller #(
    parameter int unsigned ADDRESS_WORD_SIZE = 32,
    parameter int unsigned TAG_SIZE          = 19,
    parameter int unsigned BLOCK_SIZE        = 16,
    parameter int unsigned WORD_SIZE         = 4
) (
    input logic               clk,
    input logic               rst_b,
    cache_controller_if.master bus
);

    localparam int unsigned AW      = ADDRESS_WORD_SIZE;
    localparam int unsigned Bytes   = BLOCK_SIZE * WORD_SIZE;
    localparam int unsigned OffsetW = ADDRESS_WORD_SIZE - TAG_SIZE - 7;
    localparam logic [OffsetW:0] LastBeat = (OffsetW + 1)'(Bytes - 1);

    typedef enum logic [2:0] {
        StIdle, StLookup, StCacheWr, StMemWr, StFillReq, StFill, StUpdate, StResp
    } state_e;

    state_e         state_q;
    logic [AW-1:0]  addr_q;
    logic           rw_q;
    logic [7:0]     wdata_q;
    logic [7:0]     rdata_q;
    logic [OffsetW:0] cnt_q;

    logic [1:0] hit_age;
    logic [3:0] lru_inc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cpu_req_valid) begin
                        addr_q  <= bus.cpu_addr;
                        rw_q    <= bus.cpu_rw;
                        wdata_q <= bus.cpu_wdata;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (rw_q) begin
                        state_q <= bus.hit_miss ? StCacheWr : StMemWr;
                    end else if (bus.hit_miss) begin
                        rdata_q <= bus.data;
                        state_q <= StResp;
                    end else begin
                        state_q <= StFillReq;
                    end
                end
                StCacheWr: state_q <= StMemWr;
                StMemWr: begin
                    if (bus.mem_wr_ack) state_q <= StResp;
                end
                StFillReq: begin
                    cnt_q   <= '0;
                    state_q <= StFill;
                end
                StFill: begin
                    if (bus.mem_rd_valid) begin
                        if (cnt_q[OffsetW-1:0] == addr_q[OffsetW-1:0]) rdata_q <= bus.mem_rd_data;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastBeat) state_q <= StUpdate;
                    end
                end
                StUpdate: state_q <= StResp;
                StResp:   state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Age of the hit way, then every younger way ages by one.
    always_comb begin
        hit_age = '0;
        lru_inc = '0;
        for (int k = 0; k < 4; k++) begin
            if (bus.hit_miss_set[k]) hit_age = hit_age | bus.ages[2*k +: 2];
        end
        for (int k = 0; k < 4; k++) begin
            lru_inc[k] = !bus.hit_miss_set[k] && (bus.ages[2*k +: 2] < hit_age);
        end
    end

    always_comb begin
        bus.cpu_req_ready  = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        bus.cpu_rdata      = '0;
        bus.address_word   = '0;
        bus.try_read       = 1'b0;
        bus.try_write      = 1'b0;
        bus.write_data     = '0;
        bus.reset_age      = '0;
        bus.increment_age  = '0;
        bus.mem_rd_req     = 1'b0;
        bus.mem_rd_addr    = '0;
        bus.mem_wr_req     = 1'b0;
        bus.mem_wr_addr    = '0;
        bus.mem_wr_data    = '0;
        unique case (state_q)
            StIdle: bus.cpu_req_ready = 1'b1;
            StLookup: begin
                bus.address_word = addr_q;
                bus.try_read     = 1'b1;
                if (bus.hit_miss) begin
                    bus.reset_age     = bus.hit_miss_set;
                    bus.increment_age = lru_inc;
                end
            end
            StCacheWr: begin
                bus.address_word = addr_q;
                bus.try_write    = 1'b1;
                bus.write_data   = wdata_q;
            end
            StMemWr: begin
                bus.mem_wr_req  = 1'b1;
                bus.mem_wr_addr = addr_q;
                bus.mem_wr_data = wdata_q;
            end
            StFillReq: begin
                bus.mem_rd_req  = 1'b1;
                bus.mem_rd_addr = {addr_q[AW-1:OffsetW], {OffsetW{1'b0}}};
            end
            StFill: begin
                // Beat 0 misses and allocates the age-3 victim; later beats hit it.
                if (bus.mem_rd_valid) begin
                    bus.address_word = {addr_q[AW-1:OffsetW], cnt_q[OffsetW-1:0]};
                    bus.try_write    = 1'b1;
                    bus.write_data   = bus.mem_rd_data;
                end
            end
            StUpdate: begin
                bus.address_word  = addr_q;
                bus.try_read      = 1'b1;
                bus.reset_age     = bus.hit_miss_set;
                bus.increment_age = lru_inc;
            end
            StResp: begin
                bus.cpu_resp_valid = 1'b1;
                bus.cpu_rdata      = rw_q ? 8'h00 : rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller with behavioural cache_memory and main memory.
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if #(.AW(32)) bus();

    cache_controller dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // Cache memory model: 128 sets x 4 ways x 64 bytes, ages reset to way k = 3-k.
    logic [18:0] c_tag  [128][4];
    logic        c_val  [128][4];
    logic [1:0]  c_age  [128][4];
    logic [7:0]  c_data [128][4][64];
    logic [6:0]  m_idx;
    logic [18:0] m_tag;
    logic [5:0]  m_off;
    logic [3:0]  hs;
    int          m_way;
    int          victim;

    always_comb begin
        m_idx = bus.address_word[12:6];
        m_tag = bus.address_word[31:13];
        m_off = bus.address_word[5:0];
        hs    = '0;
        m_way = 0;
        for (int w = 0; w < 4; w++) begin
            if (c_val[m_idx][w] && c_tag[m_idx][w] == m_tag) begin
                hs[w] = 1'b1;
                m_way = w;
            end
        end
        bus.hit_miss     = |hs;
        bus.hit_miss_set = hs;
        bus.data         = (|hs) ? c_data[m_idx][m_way][m_off] : 8'h00;
        bus.ages = {c_age[m_idx][3], c_age[m_idx][2], c_age[m_idx][1], c_age[m_idx][0]};
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int s = 0; s < 128; s++) begin
                for (int w = 0; w < 4; w++) begin
                    c_val[s][w] <= 1'b0;
                    c_age[s][w] <= 2'(3 - w);
                end
            end
        end else begin
            if (bus.try_write) begin
                if (|hs) begin
                    c_data[m_idx][m_way][m_off] <= bus.write_data;
                end else begin
                    victim = 0;
                    for (int w = 0; w < 4; w++) if (c_age[m_idx][w] == 2'd3) victim = w;
                    c_tag[m_idx][victim]         <= m_tag;
                    c_val[m_idx][victim]         <= 1'b1;
                    c_data[m_idx][victim][m_off] <= bus.write_data;
                end
            end
            for (int w = 0; w < 4; w++) begin
                if (bus.reset_age[w]) c_age[m_idx][w] <= 2'd0;
                else if (bus.increment_age[w]) c_age[m_idx][w] <= c_age[m_idx][w] + 2'd1;
            end
        end
    end

    // Main memory: written bytes override the default pattern.
    logic [7:0] mem_store [int unsigned];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {2'b00, a[5:0]} ^ 8'hA5 ^ a[20:13];
    endfunction

    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] exp_q [$];
    int         tw_cnt = 0;
    int         wr_cyc = 0;
    int         both_cnt = 0;
    logic [3:0] last_ra = '0;
    logic [3:0] last_ia = '0;
    logic [31:0] cap_rd_addr = '0;
    logic [31:0] cap_wr_addr = '0;
    logic [7:0]  cap_wr_data = '0;
    int         ack_delay = 1;
    bit         gap_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response and records side activity.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.try_write) tw_cnt++;
            if (bus.try_read && bus.try_write) both_cnt++;
            if (bus.reset_age != 4'h0 || bus.increment_age != 4'h0) begin
                last_ra = bus.reset_age;
                last_ia = bus.increment_age;
            end
            if (bus.mem_rd_req) cap_rd_addr = bus.mem_rd_addr;
            if (bus.mem_wr_req) begin
                wr_cyc++;
                cap_wr_addr = bus.mem_wr_addr;
                cap_wr_data = bus.mem_wr_data;
            end
            if (bus.cpu_resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_resp: got rdata 0x%0h, expected no response",
                             bus.cpu_rdata);
                end else begin
                    check("resp_rdata", 32'(bus.cpu_rdata), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Fill responder: 64 ascending beats, optional random idle cycles, abandons on reset.
    initial begin
        logic [31:0] base;
        int          b;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_b && bus.mem_rd_req) begin
                base = bus.mem_rd_addr;
                b = 0;
                @(negedge clk);
                while (b < 64 && rst_b) begin
                    if (gap_mode && $urandom_range(0, 2) == 0) begin
                        bus.mem_rd_valid = 1'b0;
                    end else begin
                        bus.mem_rd_valid = 1'b1;
                        bus.mem_rd_data  = mem_byte(base + 32'(b));
                        b++;
                    end
                    @(negedge clk);
                end
                bus.mem_rd_valid = 1'b0;
            end
        end
    end

    // Write responder: acks after ack_delay cycles of mem_wr_req.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_wr_ack) begin
                bus.mem_wr_ack = 1'b0;
                cnt = 0;
            end else if (rst_b && bus.mem_wr_req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    bus.mem_wr_ack = 1'b1;
                    mem_store[bus.mem_wr_addr] = bus.mem_wr_data;
                end
            end
        end
    end

    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int exp_lat, input bit keep);
        int guard;
        int lat;
        exp_q.push_back(rw ? 8'h00 : exp_rd);
        @(negedge clk);
        tw_cnt = 0;
        wr_cyc = 0;
        last_ra = '0;
        last_ia = '0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_rw        = rw;
        bus.cpu_addr      = addr;
        bus.cpu_wdata     = wd;
        guard = 0;
        while (!bus.cpu_req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.cpu_req_valid = 1'b0;
        check("busy_not_ready", 32'(bus.cpu_req_ready), 32'd0);
        lat = 1;
        while (!bus.cpu_resp_valid && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.cpu_resp_valid) begin
            n_vec++;
            n_miss++;
            $display("FAIL resp_timeout: got no response after %0d cycles, expected one", lat);
        end else if (exp_lat > 0) begin
            check("latency", 32'(lat), 32'(exp_lat));
        end
        #3;
    endtask

    function automatic logic outs_nonzero();
        return ({bus.address_word, bus.try_read, bus.try_write, bus.write_data, bus.reset_age,
                 bus.increment_age, bus.mem_rd_req, bus.mem_rd_addr, bus.mem_wr_req,
                 bus.mem_wr_addr, bus.mem_wr_data, bus.cpu_resp_valid, bus.cpu_rdata} != '0);
    endfunction

    logic [31:0] miss_addr [4] = '{32'h2140, 32'h4140, 32'h6140, 32'h8140};
    logic [7:0]  miss_data [4] = '{8'hA4, 8'hA7, 8'hA6, 8'hA1};

    initial begin
        int g;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_rw        = 1'b0;
        bus.cpu_addr      = '0;
        bus.cpu_wdata     = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(bus.cpu_req_ready), 32'd1);
        check("reset_outputs_zero", 32'(outs_nonzero()), 32'd0);
        rst_b = 1'b1;

        // Read miss with fill, then hit on the same byte.
        do_req(1'b0, 32'h0000_1234, 8'h00, 8'h91, 0, 1'b0);
        check("miss_try_writes", 32'(tw_cnt), 32'd64);
        check("fill_block_addr", cap_rd_addr, 32'h0000_1200);
        do_req(1'b0, 32'h0000_1234, 8'h00, 8'h91, 2, 1'b0);
        check("hit_no_try_write", 32'(tw_cnt), 32'd0);
        check("hit_reset_age", 32'(last_ra), 32'h1);
        check("hit_increment_age", 32'(last_ia), 32'h0);

        // Fill all four ways of set 5, then hit the oldest.
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, miss_addr[i], 8'h00, miss_data[i], 0, 1'b0);
            check("set5_miss_try_writes", 32'(tw_cnt), 32'd64);
        end
        do_req(1'b0, 32'h0000_2140, 8'h00, 8'hA4, 2, 1'b0);
        check("lru_reset_age", 32'(last_ra), 32'h1);
        check("lru_increment_age", 32'(last_ia), 32'hE);

        // Write hit with a 3-cycle ack, then read back.
        ack_delay = 3;
        do_req(1'b1, 32'h0000_1234, 8'hCC, 8'h00, 6, 1'b0);
        check("wr_hit_try_writes", 32'(tw_cnt), 32'd1);
        check("wr_hit_req_cycles", 32'(wr_cyc), 32'd3);
        check("wr_hit_mem_addr", cap_wr_addr, 32'h0000_1234);
        check("wr_hit_mem_data", 32'(cap_wr_data), 32'hCC);
        check("wr_hit_reset_age", 32'(last_ra), 32'h1);
        do_req(1'b0, 32'h0000_1234, 8'h00, 8'hCC, 2, 1'b0);

        // Write miss: no allocate, ages untouched; subsequent read still misses.
        ack_delay = 1;
        do_req(1'b1, 32'h0000_3000, 8'h5A, 8'h00, 3, 1'b0);
        check("wr_miss_try_writes", 32'(tw_cnt), 32'd0);
        check("wr_miss_ages", 32'({last_ra, last_ia}), 32'h0);
        check("wr_miss_req_cycles", 32'(wr_cyc), 32'd1);
        do_req(1'b0, 32'h0000_3000, 8'h00, 8'h5A, 0, 1'b0);
        check("no_allocate_miss", 32'(tw_cnt), 32'd64);

        // Request held across busy: second copy accepted only once idle again.
        do_req(1'b0, 32'h0000_8155, 8'h00, 8'hB4, 2, 1'b1);
        do_req(1'b0, 32'h0000_8155, 8'h00, 8'hB4, 2, 1'b0);

        // Fill with random gaps.
        gap_mode = 1'b1;
        do_req(1'b0, 32'h0000_A249, 8'h00, 8'hA9, 0, 1'b0);
        check("gap_fill_try_writes", 32'(tw_cnt), 32'd64);
        gap_mode = 1'b0;
        do_req(1'b0, 32'h0000_A27F, 8'h00, 8'h9F, 2, 1'b0);
        check("gap_fill_reset_age", 32'(last_ra), 32'h1);
        check("gap_fill_increment_age", 32'(last_ia), 32'h0);

        // Reset in the middle of a fill.
        @(negedge clk);
        tw_cnt = 0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_rw        = 1'b0;
        bus.cpu_addr      = 32'h0000_C000;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        g = 0;
        #3;
        while (tw_cnt < 10 && g < 500) begin
            @(negedge clk);
            #3;
            g++;
        end
        check("abort_reached_beat10", 32'(tw_cnt >= 10), 32'd1);
        rst_b = 1'b0;
        #1;
        check("abort_ready", 32'(bus.cpu_req_ready), 32'd1);
        check("abort_outputs_zero", 32'(outs_nonzero()), 32'd0);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        do_req(1'b0, 32'h0000_1234, 8'h00, 8'hCC, 0, 1'b0);
        check("after_reset_miss", 32'(tw_cnt), 32'd64);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("read_write_exclusive", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500us, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
